// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC control for an RV64 subset (ld, sd, add, sub).
// Every output is a flop; decode fields are loaded when the instruction is captured
// and held until the next capture, and enables pulse only in EXEC.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic        WE_reg,
    output logic        WE_mem,
    output logic [63:0] OFFSET,
    output logic        ADD_SUB,
    output logic        OP_MEM,
    output logic        halted
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned RIDX  = 5;
    localparam int unsigned IMM_W = 12;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic            legal;
        logic            we_reg;
        logic            we_mem;
        logic            op_mem;
        logic            add_sub;
        logic [RIDX-1:0] ra;
        logic [RIDX-1:0] rb;
        logic [RIDX-1:0] rw;
        logic [XLEN-1:0] offset;
    } dec_t;

    // Instruction decoder; anything outside the supported subset decodes as illegal with zero fields.
    function automatic dec_t decode(input logic [ILEN-1:0] w);
        dec_t            d;
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [RIDX-1:0] rd;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        d   = '0;
        opc = w[6:0];
        rd  = w[11:7];
        f3  = w[14:12];
        rs1 = w[19:15];
        rs2 = w[24:20];
        f7  = w[31:25];
        case (opc)
            OPC_LOAD: begin
                if (f3 == F3_DWORD) begin
                    d.legal  = 1'b1;
                    d.op_mem = 1'b1;
                    d.ra     = rd;
                    d.rb     = rs1;
                    d.rw     = rd;
                    d.offset = {{(XLEN-IMM_W){w[31]}}, w[31:20]};
                    d.we_reg = (rd != '0);
                end
            end
            OPC_STORE: begin
                if (f3 == F3_DWORD) begin
                    d.legal  = 1'b1;
                    d.op_mem = 1'b1;
                    d.ra     = rs2;
                    d.rb     = rs1;
                    d.rw     = '0;
                    d.offset = {{(XLEN-IMM_W){w[31]}}, w[31:25], w[11:7]};
                    d.we_mem = 1'b1;
                end
            end
            OPC_OP: begin
                if ((f3 == F3_ADD) && ((f7 == F7_ADD) || (f7 == F7_SUB))) begin
                    d.legal   = 1'b1;
                    d.ra      = rs1;
                    d.rb      = rs2;
                    d.rw      = rd;
                    d.add_sub = (f7 == F7_SUB);
                    d.we_reg  = (rd != '0);
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t          state, state_n;
    logic [ILEN-1:0] ir, ir_n;
    logic [XLEN-1:0] pc_n;
    logic [RIDX-1:0] ra_n, rb_n, rw_n;
    logic [XLEN-1:0] offset_n;
    logic            add_sub_n, op_mem_n;
    logic            we_reg_n, we_mem_n;
    logic            req_n, halted_n;
    dec_t            dec;

    // One decoder: incoming word while fetching (to load output fields), IR otherwise (legality/enables).
    assign dec = decode((state == FETCH) ? instr : ir);

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        ir_n      = ir;
        pc_n      = imem_addr;
        ra_n      = Ra;
        rb_n      = Rb;
        rw_n      = Rw;
        offset_n  = OFFSET;
        add_sub_n = ADD_SUB;
        op_mem_n  = OP_MEM;
        we_reg_n  = 1'b0;
        we_mem_n  = 1'b0;
        case (state)
            FETCH: begin
                if (instr_valid) begin
                    ir_n      = instr;
                    state_n   = DECODE;
                    ra_n      = dec.ra;
                    rb_n      = dec.rb;
                    rw_n      = dec.rw;
                    offset_n  = dec.offset;
                    add_sub_n = dec.add_sub;
                    op_mem_n  = dec.op_mem;
                end
            end
            DECODE: begin
                if (dec.legal) begin
                    state_n  = EXEC;
                    we_reg_n = dec.we_reg;
                    we_mem_n = dec.we_mem;
                end else begin
                    state_n = HALT;
                end
            end
            EXEC: begin
                pc_n    = imem_addr + PC_STEP;
                state_n = FETCH;
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
        req_n    = (state_n == FETCH);
        halted_n = (state_n == HALT);
    end

    // State, IR, PC and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            ir        <= '0;
            imem_addr <= '0;
            imem_req  <= 1'b1;
            Ra        <= '0;
            Rb        <= '0;
            Rw        <= '0;
            OFFSET    <= '0;
            ADD_SUB   <= 1'b0;
            OP_MEM    <= 1'b0;
            WE_reg    <= 1'b0;
            WE_mem    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            ir        <= ir_n;
            imem_addr <= pc_n;
            imem_req  <= req_n;
            Ra        <= ra_n;
            Rb        <= rb_n;
            Rw        <= rw_n;
            OFFSET    <= offset_n;
            ADD_SUB   <= add_sub_n;
            OP_MEM    <= op_mem_n;
            WE_reg    <= we_reg_n;
            WE_mem    <= we_mem_n;
            halted    <= halted_n;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [4:0]  Ra, Rb, Rw;
    logic        WE_reg, WE_mem;
    logic [63:0] OFFSET;
    logic        ADD_SUB, OP_MEM, halted;

    control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE_reg(WE_reg), .WE_mem(WE_mem),
        .OFFSET(OFFSET), .ADD_SUB(ADD_SUB), .OP_MEM(OP_MEM), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra, rb, rw;
        logic [63:0] off;
        logic        add_sub, op_mem, we_reg, we_mem, halt;
        logic [63:0] pc_before, pc_after;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    logic [63:0] model_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction's architectural meaning, not the FSM.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
        exp_t       e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        longint     imm;
        e   = '{default: '0};
        opc = w[6:0];   rd  = w[11:7];  f3 = w[14:12];
        rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
        e.pc_before = pc;
        e.halt = 1'b1;
        if (opc == 7'h03 && f3 == 3'd3) begin
            imm = longint'(w[31:20]);
            if (imm >= 2048) imm -= 4096;
            e.halt = 1'b0; e.op_mem = 1'b1;
            e.ra = rd; e.rb = rs1; e.rw = rd; e.off = 64'(imm);
            e.we_reg = (rd != 5'd0);
        end else if (opc == 7'h23 && f3 == 3'd3) begin
            imm = longint'({w[31:25], w[11:7]});
            if (imm >= 2048) imm -= 4096;
            e.halt = 1'b0; e.op_mem = 1'b1;
            e.ra = rs2; e.rb = rs1; e.rw = 5'd0; e.off = 64'(imm);
            e.we_mem = 1'b1;
        end else if (opc == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) begin
            e.halt = 1'b0;
            e.ra = rs1; e.rb = rs2; e.rw = rd; e.off = 64'd0;
            e.add_sub = (f7 == 7'h20);
            e.we_reg = (rd != 5'd0);
        end
        e.pc_after = e.halt ? pc : pc + 64'd4;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    w = {imm, rs1, 3'b011, rd, 7'b0000011};
            2, 3:    w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
            4, 5:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            6:       w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            7:       w = {imm, rs1, 3'($urandom), rd, 7'b0000011};
            8:       w = {7'($urandom), rs2, rs1, 3'($urandom_range(0, 1)), rd, 7'b0110011};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        instr_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_we_reg", 64'(WE_reg), 64'd0);
        chk("rst_we_mem", 64'(WE_mem), 64'd0);
        chk("rst_fields", {35'd0, Ra, Rb, Rw, ADD_SUB, OP_MEM, 12'd0}, 64'd0);
        chk("rst_offset", OFFSET, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_imem_req", 64'(imem_req), 64'd1);
        model_pc = '0;
        sb.delete();
        tick();
        mon_en = 1'b1;
    endtask

    // Drive one instruction; expected response goes to the scoreboard when the word is offered.
    task automatic issue(input logic [31:0] w, input int gap, input bit rst_in_exec, output bit halts);
        exp_t e;
        int   budget;
        budget = 20;
        halts  = 1'b0;
        while (!imem_req && budget > 0) begin
            instr_valid = 1'($urandom);
            instr = $urandom;
            tick();
            budget--;
        end
        if (!imem_req) begin
            chk("fetch_wait_timeout", 64'(imem_req), 64'd1);
            do_reset();
        end
        for (int i = 0; i < gap; i++) begin
            instr_valid = 1'b0;
            instr = $urandom;
            tick();
        end
        e = model(w, model_pc);
        sb.push_back(e);
        halts = e.halt;
        if (!e.halt) model_pc = e.pc_after;
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'($urandom);
        instr = $urandom;
        if (rst_in_exec) begin
            tick();
            rst = 1'b1;
            instr_valid = 1'b0;
            @(negedge clk);
            #1 mon_en = 1'b0;
            @(negedge clk);
            chk("rst_exec_we_reg", 64'(WE_reg), 64'd0);
            chk("rst_exec_we_mem", 64'(WE_mem), 64'd0);
            chk("rst_exec_pc", imem_addr, 64'd0);
            chk("rst_exec_halted", 64'(halted), 64'd0);
            tick();
            rst = 1'b0;
            model_pc = '0;
            sb.delete();
            mon_en = 1'b1;
        end
    endtask

    // Monitor: detects DECODE (imem_req falling), then follows EXEC/HALT and the next FETCH.
    initial begin : monitor
        exp_t e;
        int   phase;
        bit   prev_req;
        e = '{default: '0};
        phase = 0;
        prev_req = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                phase = 0;
                prev_req = 1'b1;
                continue;
            end
            case (phase)
                0: begin
                    if (imem_req) begin
                        chk("fetch_no_we", {62'd0, WE_reg, WE_mem}, 64'd0);
                    end else if (prev_req) begin
                        chk("decode_expected", 64'(sb.size() > 0), 64'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("dec_no_we", {62'd0, WE_reg, WE_mem}, 64'd0);
                            chk("dec_halted", 64'(halted), 64'd0);
                            if (!e.halt) begin
                                chk("dec_ra", 64'(Ra), 64'(e.ra));
                                chk("dec_rb", 64'(Rb), 64'(e.rb));
                                chk("dec_rw", 64'(Rw), 64'(e.rw));
                                chk("dec_offset", OFFSET, e.off);
                                chk("dec_add_sub", 64'(ADD_SUB), 64'(e.add_sub));
                                chk("dec_op_mem", 64'(OP_MEM), 64'(e.op_mem));
                            end
                            phase = 1;
                        end
                    end
                end
                1: begin
                    chk("exec_we_reg", 64'(WE_reg), 64'(e.we_reg));
                    chk("exec_we_mem", 64'(WE_mem), 64'(e.we_mem));
                    chk("exec_halted", 64'(halted), 64'(e.halt));
                    chk("exec_imem_req", 64'(imem_req), 64'd0);
                    chk("exec_pc", imem_addr, e.pc_before);
                    if (!e.halt) begin
                        chk("exec_stable", {35'd0, Ra, Rb, Rw, ADD_SUB, OP_MEM, 12'd0},
                            {35'd0, e.ra, e.rb, e.rw, e.add_sub, e.op_mem, 12'd0});
                        chk("exec_offset", OFFSET, e.off);
                    end
                    phase = e.halt ? 3 : 2;
                end
                2: begin
                    chk("next_fetch_req", 64'(imem_req), 64'd1);
                    chk("next_fetch_pc", imem_addr, e.pc_after);
                    chk("next_fetch_no_we", {62'd0, WE_reg, WE_mem}, 64'd0);
                    phase = 0;
                end
                default: begin
                    chk("halt_hold", {61'd0, halted, WE_reg, WE_mem}, 64'd4);
                    chk("halt_no_req", 64'(imem_req), 64'd0);
                    chk("halt_pc", imem_addr, e.pc_before);
                end
            endcase
            prev_req = imem_req;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit h;
        logic [31:0] w;
        do_reset();
        issue(32'h00103083, 0, 1'b0, h);
        issue(32'h001101B3, 0, 1'b0, h);
        issue(32'h40118233, 0, 1'b0, h);
        issue(32'h003031A3, 0, 1'b0, h);
        issue(32'hFF813283, 0, 1'b0, h);
        issue(32'h001101B3, 5, 1'b0, h);
        issue(32'h00103003, 0, 1'b0, h);
        issue(32'h00000000, 0, 1'b0, h);
        repeat (4) tick();
        do_reset();
        issue(32'h001101B3, 0, 1'b1, h);
        issue(32'h00103083, 2, 1'b0, h);
        for (int n = 0; n < 300; n++) begin
            w = rand_instr();
            issue(w, $urandom_range(0, 3), ($urandom_range(0, 19) == 0), h);
            if (h) begin
                repeat (3) tick();
                do_reset();
            end
        end
        repeat (4) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
